dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port 0 = CPU load/store path, port 1 = loader/debug port.

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/dmem_rr_picker.sv | 22 ++
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state, requester id and port ids.
package dmem_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_CPU = 1'b0;
    localparam req_id_t REQ_LDR = 1'b1;

endpackage

// File: rtl/dmem_rr_picker.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port that did not win last.
module dmem_rr_picker
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    rr_last,
    output req_id_t    winner,
    output logic       any
);

    always_comb begin
        any = |req;
        if (&req) begin
            winner = ~rr_last;
        end else if (req[1]) begin
            winner = REQ_LDR;
        end else begin
            winner = REQ_CPU;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and loader/debug (port 1).
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
`ifdef DMEM_ARB_STATS_EN
    ,
    parameter int STAT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output arb_state_t        dbg_state
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_gnt0,
    output logic [STAT_W-1:0] stat_gnt1,
    output logic [STAT_W-1:0] stat_wait
`endif
);

    arb_state_t state;
    req_id_t    lock_id;
    req_id_t    rr_last;
    req_id_t    resp_id;
    logic       resp_valid;

    logic [1:0] eligible;
    req_id_t    winner;
    logic       any;
    logic       win_lock;
    logic       owner_req;

    // While locked only the owner may compete; nothing is issued in a reset cycle.
    always_comb begin
        eligible = {req1, req0};
        if (state == ARB_LOCKED) begin
            eligible = (lock_id == REQ_LDR) ? {req1, 1'b0} : {1'b0, req0};
        end
        if (reset) begin
            eligible = 2'b00;
        end
    end

    dmem_rr_picker u_picker (
        .req     (eligible),
        .rr_last (rr_last),
        .winner  (winner),
        .any     (any)
    );

    assign gnt0      = any && (winner == REQ_CPU);
    assign gnt1      = any && (winner == REQ_LDR);
    assign win_lock  = (winner == REQ_LDR) ? lock1 : lock0;
    assign owner_req = (lock_id == REQ_LDR) ? req1 : req0;

    always_comb begin
        mem_en    = any;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (any) begin
            if (winner == REQ_LDR) begin
                mem_we    = we1;
                mem_addr  = addr1;
                mem_wdata = wdata1;
            end else begin
                mem_we    = we0;
                mem_addr  = addr0;
                mem_wdata = wdata0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            lock_id    <= REQ_CPU;
            rr_last    <= REQ_LDR;
            resp_valid <= 1'b0;
            resp_id    <= REQ_CPU;
        end else begin
            resp_valid <= any;
            resp_id    <= winner;
            case (state)
                ARB_IDLE: begin
                    if (any) begin
                        rr_last <= winner;
                        if (win_lock) begin
                            state   <= ARB_LOCKED;
                            lock_id <= winner;
                        end
                    end
                end
                ARB_LOCKED: begin
                    // Owner leaving, or issuing its final unlocked access, frees the memory.
                    if (!owner_req || (any && !win_lock)) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign rvalid0   = resp_valid && !reset && (resp_id == REQ_CPU);
    assign rvalid1   = resp_valid && !reset && (resp_id == REQ_LDR);
    assign rdata     = mem_rdata;
    assign dbg_state = state;

`ifdef DMEM_ARB_STATS_EN
    logic waiting;
    assign waiting = (req0 && !gnt0) || (req1 && !gnt1);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_gnt0 <= '0;
            stat_gnt1 <= '0;
            stat_wait <= '0;
        end else begin
            if (gnt0 && (stat_gnt0 != '1)) stat_gnt0 <= stat_gnt0 + 1'b1;
            if (gnt1 && (stat_gnt1 != '1)) stat_gnt1 <= stat_gnt1 + 1'b1;
            if (waiting && (stat_wait != '1)) stat_wait <= stat_wait + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic against a cycle-level reference model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              req0, we0, lock0, req1, we1, lock1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
    logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    arb_state_t        dbg_state;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_gnt0, stat_gnt1, stat_wait;
    logic [1:0]  s2_gnt0, s2_gnt1, s2_wait;
    logic        d2_gnt0, d2_gnt1, d2_rv0, d2_rv1, d2_en, d2_we;
    logic [DATA_W-1:0] d2_rdata, d2_wdata;
    logic [ADDR_W-1:0] d2_addr;
    arb_state_t        d2_state;
`endif

    dmem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
`ifdef DMEM_ARB_STATS_EN
        ,
        .STAT_W (16)
`endif
    ) u_dut (
        .clk (clk), .reset (reset),
        .req0 (req0), .we0 (we0), .lock0 (lock0), .addr0 (addr0), .wdata0 (wdata0),
        .req1 (req1), .we1 (we1), .lock1 (lock1), .addr1 (addr1), .wdata1 (wdata1),
        .gnt0 (gnt0), .gnt1 (gnt1), .rvalid0 (rvalid0), .rvalid1 (rvalid1), .rdata (rdata),
        .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata), .dbg_state (dbg_state)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_gnt0 (stat_gnt0), .stat_gnt1 (stat_gnt1), .stat_wait (stat_wait)
`endif
    );

`ifdef DMEM_ARB_STATS_EN
    dmem_arbiter #(.ADDR_W (ADDR_W), .DATA_W (DATA_W), .STAT_W (2)) u_dut2 (
        .clk (clk), .reset (reset),
        .req0 (req0), .we0 (we0), .lock0 (lock0), .addr0 (addr0), .wdata0 (wdata0),
        .req1 (req1), .we1 (we1), .lock1 (lock1), .addr1 (addr1), .wdata1 (wdata1),
        .gnt0 (d2_gnt0), .gnt1 (d2_gnt1), .rvalid0 (d2_rv0), .rvalid1 (d2_rv1), .rdata (d2_rdata),
        .mem_en (d2_en), .mem_we (d2_we), .mem_addr (d2_addr), .mem_wdata (d2_wdata),
        .mem_rdata (mem_rdata), .dbg_state (d2_state),
        .stat_gnt0 (s2_gnt0), .stat_gnt1 (s2_gnt1), .stat_wait (s2_wait)
    );
`endif

    // Environment memory: registered read, writes land at the access edge.
    logic [DATA_W-1:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [DATA_W-1:0] ref_mem [0:255];
    logic [DATA_W-1:0] exp_q[$];
    int   last_w = 1;
    int   owner = -1;
    bit   pend_v = 0;
    int   pend_id = 0;
    bit   pend_rd = 0;
    bit   g0, g1;
    logic [15:0] sg0 = '0, sg1 = '0, sw = '0;
    logic [1:0]  tg0 = '0, tg1 = '0, tw = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int   w;
        bit   e0, e1, lk, wr, waiting;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d, dexp;
        @(negedge clk);
        e0 = req0;
        e1 = req1;
        if (reset) begin
            e0 = 0; e1 = 0;
        end else if (owner == 0) begin
            e1 = 0;
        end else if (owner == 1) begin
            e0 = 0;
        end
        if (e0 && e1)  w = (last_w == 0) ? 1 : 0;
        else if (e0)   w = 0;
        else if (e1)   w = 1;
        else           w = -1;
        g0 = (w == 0);
        g1 = (w == 1);
        lk = (w == 1) ? lock1 : lock0;
        wr = (w == 1) ? we1 : we0;
        a  = (w == 1) ? addr1 : addr0;
        d  = (w == 1) ? wdata1 : wdata0;

        check("gnt0", gnt0, g0);
        check("gnt1", gnt1, g1);
        check("mem_en", mem_en, (w >= 0));
        if (w >= 0) begin
            check("mem_we", mem_we, wr);
            check("mem_addr", mem_addr, a);
            if (wr) check("mem_wdata", mem_wdata, d);
        end else begin
            check("mem_we_idle", mem_we, 1'b0);
        end
        check("rvalid0", rvalid0, pend_v && !reset && pend_id == 0);
        check("rvalid1", rvalid1, pend_v && !reset && pend_id == 1);
        if (pend_v && pend_rd) begin
            dexp = exp_q.pop_front();
            if (!reset) check("rdata", rdata, dexp);
        end
        check("state", dbg_state, (owner >= 0) ? ARB_LOCKED : ARB_IDLE);
`ifdef DMEM_ARB_STATS_EN
        check("stat_gnt0", stat_gnt0, sg0);
        check("stat_gnt1", stat_gnt1, sg1);
        check("stat_wait", stat_wait, sw);
        check("stat2_gnt0", s2_gnt0, tg0);
        check("stat2_gnt1", s2_gnt1, tg1);
        check("stat2_wait", s2_wait, tw);
`endif

        if (reset) begin
            pend_v = 0; pend_rd = 0; owner = -1; last_w = 1;
            exp_q.delete();
            sg0 = '0; sg1 = '0; sw = '0; tg0 = '0; tg1 = '0; tw = '0;
        end else begin
            waiting = (req0 && !g0) || (req1 && !g1);
            if (g0 && sg0 != 16'hffff) sg0++;
            if (g1 && sg1 != 16'hffff) sg1++;
            if (waiting && sw != 16'hffff) sw++;
            if (g0 && tg0 != 2'd3) tg0++;
            if (g1 && tg1 != 2'd3) tg1++;
            if (waiting && tw != 2'd3) tw++;
            pend_v  = (w >= 0);
            pend_id = w;
            pend_rd = 0;
            if (w >= 0) begin
                if (wr) begin
                    ref_mem[a] = d;
                end else begin
                    exp_q.push_back(ref_mem[a]);
                    pend_rd = 1;
                end
                if (owner < 0) begin
                    last_w = w;
                    if (lk) owner = w;
                end else if (!lk) begin
                    owner = -1;
                end
            end else if (owner >= 0) begin
                owner = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input bit r, input bit w, input int a, input logic [DATA_W-1:0] d, input bit l);
        req0 = r; we0 = w; addr0 = ADDR_W'(a); wdata0 = d; lock0 = l;
    endtask

    task automatic drive1(input bit r, input bit w, input int a, input logic [DATA_W-1:0] d, input bit l);
        req1 = r; we1 = w; addr1 = ADDR_W'(a); wdata1 = d; lock1 = l;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = DATA_W'(i * 7 + 1000);
            ref_mem[i] = DATA_W'(i * 7 + 1000);
        end
        mem[15] = 123;
        ref_mem[15] = 123;
        mem_rdata = '0;
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        reset = 1;
        @(posedge clk);
        #1;
        tick();
        reset = 0;

        // Single CPU read
        drive0(1, 0, 15, 0, 0);
        tick();
        drive0(0, 0, 0, 0, 0);
        tick();
        tick();

        // Both ports reading continuously alternate
        drive0(1, 0, 3, 0, 0);
        drive1(1, 0, 9, 0, 0);
        repeat (4) tick();
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        tick();

        // Locked write/read by loader while CPU waits
        drive1(1, 1, 16, 30, 1);
        tick();
        drive1(1, 0, 16, 0, 0);
        drive0(1, 0, 2, 0, 0);
        tick();
        drive1(0, 0, 0, 0, 0);
        tick();
        drive0(0, 0, 0, 0, 0);
        tick();

        // Back-to-back write then read of the same word
        drive0(1, 1, 5, 7, 0);
        tick();
        drive0(1, 0, 5, 0, 0);
        tick();
        drive0(0, 0, 0, 0, 0);
        tick();

        // Reset right after a grant drops the response
        drive0(1, 0, 1, 0, 0);
        tick();
        drive0(0, 0, 0, 0, 0);
        reset = 1;
        tick();
        reset = 0;
        drive1(1, 0, 2, 0, 0);
        tick();
        drive1(0, 0, 0, 0, 0);
        tick();

`ifdef DMEM_ARB_STATS_EN
        reset = 1;
        tick();
        reset = 0;
        drive0(1, 0, 4, 0, 0);
        drive1(1, 0, 6, 0, 0);
        repeat (6) tick();
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        tick();
        check("stats_gnt0_after6", stat_gnt0, 16'd3);
        check("stats_gnt1_after6", stat_gnt1, 16'd3);
        check("stats_wait_after6", stat_wait, 16'd6);
        check("stats2_wait_sat", s2_wait, 2'd3);
`endif

        // Random traffic: each port holds its request until granted
        for (int n = 0; n < 400; n++) begin
            if (!req0 || g0)
                drive0($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                       $urandom, $urandom_range(0, 3) == 0);
            if (!req1 || g1)
                drive1($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                       $urandom, $urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 60) == 0);
            tick();
        end
        reset = 0;
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
